// File: rtl/sonar_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sonar_pkg
//  Description : Shared definitions for the sonar ping sequencer: bus width,
//                time-of-flight timeout code and FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package sonar_pkg;

  localparam int BUS_WIDTH = 16;

  // Reported as tof when the listen window closes without an echo.
  localparam logic [BUS_WIDTH-1:0] TOF_TIMEOUT = '1;

  // Encodings exposed through state_o to the status register.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_TX     = 3'd2;
  localparam logic [2:0] ST_BLANK  = 3'd3;
  localparam logic [2:0] ST_LISTEN = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_CLEAR  = ST_CLEAR,
    S_TX     = ST_TX,
    S_BLANK  = ST_BLANK,
    S_LISTEN = ST_LISTEN,
    S_DONE   = ST_DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sonar_tick_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sonar_tick_counter
//  Description : Clearable, enabled up-counter with a terminal-value compare.
//                With SATURATE set the count sticks at all-ones instead of
//                wrapping.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                clear          - zero the count (wins over enable)
//                enable         - advance by one
//                terminal       - value compared against the count
//                count          - current count
//                at_terminal    - count equals terminal
//  Revision    : 1.0 - initial release
// ============================================================================
module sonar_tick_counter #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             at_terminal
);

  logic [WIDTH-1:0] r_count;
  logic             w_hold;

  generate
    if (SATURATE) begin : g_saturate
      assign w_hold = &r_count;
    end else begin : g_wrap
      assign w_hold = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !w_hold) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count       = r_count;
  assign at_terminal = (r_count == terminal);

endmodule
`default_nettype wire

// File: rtl/sonar_ping_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sonar_ping_sequencer
//  Description : Runs one sonar ping: clear detector, transmit burst, blank
//                ring-down, listen for an echo, then report time-of-flight.
//                All phase lengths are counted in PCM sample ticks.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                ce_pcm                - PCM sample tick
//                start, abort          - launch / cancel a ping
//                cfg_burst/blank/window- phase lengths in ticks
//                cmp_i                 - latched detector compare output
//                tx_en, mclear_o       - transducer enable, detector clear
//                listen_o, busy, done  - window open, active, completion pulse
//                hit, tof              - echo flag and time-of-flight
//                state_o               - current state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
module sonar_ping_sequencer
  import sonar_pkg::*;
#(
  parameter int BUS_WIDTH = sonar_pkg::BUS_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce_pcm,
  input  logic                 start,
  input  logic                 abort,
  input  logic [BUS_WIDTH-1:0] cfg_burst,
  input  logic [BUS_WIDTH-1:0] cfg_blank,
  input  logic [BUS_WIDTH-1:0] cfg_window,
  input  logic                 cmp_i,
  output logic                 tx_en,
  output logic                 mclear_o,
  output logic                 listen_o,
  output logic                 busy,
  output logic                 done,
  output logic                 hit,
  output logic [BUS_WIDTH-1:0] tof,
  output logic [2:0]           state_o
);

  state_t               r_state;
  state_t               w_state_next;

  logic [BUS_WIDTH-1:0] r_burst;
  logic [BUS_WIDTH-1:0] r_blank;
  logic [BUS_WIDTH-1:0] r_window;
  logic [BUS_WIDTH-1:0] r_tof;
  logic                 r_hit;

  logic                 w_capture;
  logic                 w_result_load;
  logic                 w_result_hit;
  logic [BUS_WIDTH-1:0] w_result_tof;

  logic [BUS_WIDTH-1:0] w_phase_len;
  logic [BUS_WIDTH-1:0] w_phase_last;
  logic                 w_phase_at_last;
  logic                 w_phase_clear;
  logic                 w_timed_enable;
  logic [BUS_WIDTH-1:0] w_phase_count_unused;
  logic [BUS_WIDTH-1:0] w_elapsed;
  logic                 w_elapsed_max_unused;

  // The phase counter restarts at zero on every state change, so each timed
  // state measures its own length against its own shadowed configuration.
  always_comb begin
    w_phase_len = r_window;
    case (r_state)
      S_TX:    w_phase_len = r_burst;
      S_BLANK: w_phase_len = r_blank;
      default: w_phase_len = r_window;
    endcase
  end

  assign w_phase_last   = w_phase_len - BUS_WIDTH'(1);
  assign w_timed_enable = ce_pcm &&
                          ((r_state == S_TX) || (r_state == S_BLANK) ||
                           (r_state == S_LISTEN));
  assign w_phase_clear  = (w_state_next != r_state);

  sonar_tick_counter #(
    .WIDTH    (BUS_WIDTH),
    .SATURATE (1'b0)
  ) u_phase_cnt (
    .clk         (clk),
    .rst         (rst),
    .clear       (w_phase_clear),
    .enable      (w_timed_enable),
    .terminal    (w_phase_last),
    .count       (w_phase_count_unused),
    .at_terminal (w_phase_at_last)
  );

  // Elapsed time from burst start; sticks at all-ones for very long pings.
  sonar_tick_counter #(
    .WIDTH    (BUS_WIDTH),
    .SATURATE (1'b1)
  ) u_elapsed_cnt (
    .clk         (clk),
    .rst         (rst),
    .clear       (r_state == S_CLEAR),
    .enable      (w_timed_enable),
    .terminal    ({BUS_WIDTH{1'b1}}),
    .count       (w_elapsed),
    .at_terminal (w_elapsed_max_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_capture     = 1'b0;
    w_result_load = 1'b0;
    w_result_hit  = 1'b0;
    w_result_tof  = TOF_TIMEOUT;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_CLEAR;
          w_capture    = 1'b1;
        end
      end
      S_CLEAR: begin
        if (r_burst != '0) begin
          w_state_next = S_TX;
        end else if (r_blank != '0) begin
          w_state_next = S_BLANK;
        end else begin
          w_state_next = S_LISTEN;
        end
      end
      S_TX: begin
        if (ce_pcm && w_phase_at_last) begin
          w_state_next = (r_blank != '0) ? S_BLANK : S_LISTEN;
        end
      end
      S_BLANK: begin
        if (ce_pcm && w_phase_at_last) begin
          w_state_next = S_LISTEN;
        end
      end
      S_LISTEN: begin
        // Echo is sampled every clock and beats a coincident window expiry.
        if (cmp_i) begin
          w_state_next  = S_DONE;
          w_result_load = 1'b1;
          w_result_hit  = 1'b1;
          w_result_tof  = w_elapsed;
        end else if ((r_window == '0) || (ce_pcm && w_phase_at_last)) begin
          w_state_next  = S_DONE;
          w_result_load = 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Abort drops the ping without touching the previous result.
    if (abort) begin
      w_state_next  = S_IDLE;
      w_capture     = 1'b0;
      w_result_load = 1'b0;
    end

    tx_en    = (r_state == S_TX);
    mclear_o = (r_state == S_CLEAR) || (r_state == S_BLANK);
    listen_o = (r_state == S_LISTEN);
    done     = (r_state == S_DONE);
    busy     = (r_state != S_IDLE);
    state_o  = r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_burst  <= '0;
      r_blank  <= '0;
      r_window <= '0;
      r_tof    <= '0;
      r_hit    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_burst  <= cfg_burst;
        r_blank  <= cfg_blank;
        r_window <= cfg_window;
      end
      if (w_result_load) begin
        r_tof <= w_result_tof;
        r_hit <= w_result_hit;
      end
    end
  end

  assign tof = r_tof;
  assign hit = r_hit;

endmodule
`default_nettype wire
